// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and state encodings for the keycode receiver
// and the character-movement block.
package ps2_pkg;

    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PARITY,
        F_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        P_NORM,
        P_EXT,
        P_BRK,
        P_EXT_BRK
    } prefix_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizer, falling-edge detect, 11-bit frame capture, timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
//
// state    | meaning
// F_IDLE   | waiting for a start bit (data 0 on a clock edge)
// F_DATA   | shifting in D0..D7, LSB first
// F_PARITY | parity bit edge
// F_STOP   | stop bit edge, byte accepted or discarded
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_strobe,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;
    frame_state_t           state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic [CNT_W-1:0]       to_cnt;
    logic                   byte_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic                   parity_bit;
`endif

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Evaluated on the stop-bit edge, so data_s is the stop bit itself.
`ifdef PS2_PARITY_CHECK_EN
    assign byte_ok = data_s & (^{shift, parity_bit});
`else
    assign byte_ok = data_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync    <= '0;
            data_sync   <= '0;
            clk_prev    <= 1'b0;
            state       <= F_IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            to_cnt      <= '0;
            byte_strobe <= 1'b0;
            rx_byte     <= 8'h00;
            frame_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync   <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev    <= clk_s;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;

            if (fall) begin
                to_cnt <= '0;
                case (state)
                    F_IDLE: begin
                        if (!data_s) begin
                            state   <= F_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    F_DATA: begin
                        shift <= {data_s, shift[7:1]};
                        if (bit_cnt == 3'd7) state <= F_PARITY;
                        else bit_cnt <= bit_cnt + 3'd1;
                    end
                    F_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= data_s;
`endif
                        state <= F_STOP;
                    end
                    default: begin
                        if (byte_ok) begin
                            byte_strobe <= 1'b1;
                            rx_byte     <= shift;
                        end else begin
                            frame_err   <= 1'b1;
                        end
                        state <= F_IDLE;
                    end
                endcase
            end else if (state == F_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                to_cnt    <= '0;
                state     <= F_IDLE;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keycode receiver top: E0/F0 prefix decode and the held-keycode register.
// Optional parity enforcement in ps2_frame_rx is selected by PS2_PARITY_CHECK_EN.
//
// state     | meaning
// P_NORM    | no prefix seen
// P_EXT     | E0 seen
// P_BRK     | F0 seen
// P_EXT_BRK | E0 F0 seen
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       ext_key,
    output logic       byte_strobe,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    prefix_state_t pstate;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_strobe(byte_strobe),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate  <= P_NORM;
            keycode <= 8'h00;
            ext_key <= 1'b0;
        end else if (frame_err) begin
            pstate <= P_NORM;
        end else if (byte_strobe) begin
            case (pstate)
                P_NORM: begin
                    if (rx_byte == PREFIX_EXT) pstate <= P_EXT;
                    else if (rx_byte == PREFIX_BRK) pstate <= P_BRK;
                    else begin
                        keycode <= rx_byte;
                        ext_key <= 1'b0;
                    end
                end
                P_EXT: begin
                    if (rx_byte == PREFIX_BRK) pstate <= P_EXT_BRK;
                    else begin
                        keycode <= rx_byte;
                        ext_key <= 1'b1;
                        pstate  <= P_NORM;
                    end
                end
                P_BRK: begin
                    // Only the held key can be released; others are ignored.
                    if (rx_byte == keycode && !ext_key) begin
                        keycode <= 8'h00;
                        ext_key <= 1'b0;
                    end
                    pstate <= P_NORM;
                end
                default: begin
                    if (rx_byte == keycode && ext_key) begin
                        keycode <= 8'h00;
                        ext_key <= 1'b0;
                    end
                    pstate <= P_NORM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: randomized PS/2 frames against a prefix/keycode model.
module tb_ps2_keycode_rx;

    localparam int TIMEOUT = 50000;
    localparam int HALF    = 10;

    localparam int K_BYTE = 0;
    localparam int K_ERR  = 1;
    localparam int K_TMO  = 2;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       ext_key;
    logic       byte_strobe;
    logic [7:0] rx_byte;
    logic       frame_err;

    ps2_keycode_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .ext_key    (ext_key),
        .byte_strobe(byte_strobe),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] b;
        logic [7:0] kc;
        logic       ext;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  last_fall_cyc = 0;

    // Reference model: held key plus pending prefix flags.
    logic [7:0] m_kc  = 8'h00;
    logic       m_ext = 1'b0;
    bit         m_pre_ext = 0;
    bit         m_pre_brk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pre_brk) begin
            if (b == m_kc && m_ext == m_pre_ext) begin
                m_kc  = 8'h00;
                m_ext = 1'b0;
            end
            m_pre_brk = 0;
            m_pre_ext = 0;
        end else if (b == 8'hF0) begin
            m_pre_brk = 1;
        end else if (b == 8'hE0 && !m_pre_ext) begin
            m_pre_ext = 1;
        end else begin
            m_kc      = b;
            m_ext     = m_pre_ext;
            m_pre_ext = 0;
        end
    endtask

    task automatic expect_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        ev_t e;
        bit  good;
`ifdef PS2_PARITY_CHECK_EN
        good = !stop_bad && !par_bad;
`else
        good = !stop_bad;
`endif
        if (good) begin
            model_byte(b);
            e.kind = K_BYTE;
        end else begin
            m_pre_ext = 0;
            m_pre_brk = 0;
            e.kind = K_ERR;
        end
        e.b   = b;
        e.kc  = m_kc;
        e.ext = m_ext;
        sb.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit par_bad, input bit stop_bad, input int nbits);
        logic [10:0] fr;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = (~^b) ^ par_bad;
        fr[10]  = ~stop_bad;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        expect_frame(b, par_bad, stop_bad);
        send_bits(b, par_bad, stop_bad, 11);
        repeat (30) @(posedge clk);
    endtask

    task automatic check_idle(input string name, input logic [7:0] kc, input logic ext);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, "_drain"}, sb.size(), 0);
        check({name, "_kc"}, keycode, kc);
        check({name, "_ext"}, ext_key, ext);
    endtask

    // Monitor: pops the scoreboard on every strobe/error, checks keycode the next cycle.
    bit         chk_kc = 0;
    logic [7:0] kc_exp;
    logic       ext_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_kc) begin
                check("keycode", keycode, kc_exp);
                check("ext_key", ext_key, ext_exp);
                chk_kc = 0;
            end
            if (byte_strobe || frame_err) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: strobe=%0b err=%0b byte=%0h expected none", byte_strobe, frame_err, rx_byte);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    if (e.kind == K_BYTE) begin
                        check("byte_strobe", byte_strobe, 1);
                        check("rx_byte", rx_byte, e.b);
                    end else begin
                        check("frame_err", frame_err, 1);
                        check("err_no_strobe", byte_strobe, 0);
                    end
                    if (e.kind == K_TMO) begin
                        total++;
                        if (cyc - last_fall_cyc < TIMEOUT || cyc - last_fall_cyc > TIMEOUT + 10) begin
                            bad++;
                            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", cyc - last_fall_cyc, TIMEOUT, TIMEOUT + 10);
                        end
                    end
                    kc_exp  = e.kc;
                    ext_exp = e.ext;
                    chk_kc  = 1;
                end
            end
        end
    end

    logic [7:0] keys[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

    initial begin
        ev_t te;
        int  r;
        logic [7:0] b;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_keycode", keycode, 0);
        check("rst_ext", ext_key, 0);
        check("rst_strobe", byte_strobe, 0);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Extended make / extended break
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        check_idle("ext_make", 8'h75, 1);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        check_idle("ext_break", 8'h00, 0);

        // Overlapping keys: last pressed wins
        send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h6B, 0, 0);
        check_idle("overlap_hold", 8'h74, 1);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h74, 0, 0);
        check_idle("overlap_rel", 8'h00, 0);

        // Bad frames, plus typematic repeat and non-extended break mismatch
        send_frame(8'h72, 0, 0);
        send_frame(8'h72, 0, 0);
        send_frame(8'h75, 0, 1);
        check_idle("bad_stop", 8'h72, 0);
        send_frame(8'h75, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
        check_idle("bad_par", 8'h72, 0);
`else
        check_idle("bad_par", 8'h75, 0);
`endif
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        check_idle("ext_mismatch", m_kc, m_ext);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r < 6) b = keys[$urandom_range(0, 3)];
            else b = 8'($urandom);
            send_frame(b, ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0));
        end
        check_idle("random", m_kc, m_ext);

        // Timeout on a partial frame, then a clean frame
        m_pre_ext = 0;
        m_pre_brk = 0;
        te.kind = K_TMO; te.b = 8'h00; te.kc = m_kc; te.ext = m_ext;
        sb.push_back(te);
        send_bits(8'h0F, 0, 0, 5);
        repeat (TIMEOUT + 40) @(posedge clk);
        check("timeout_drain", sb.size(), 0);
        send_frame(8'h72, 0, 0);
        check_idle("after_tmo", 8'h72, 0);

        // Reset mid-frame
        send_bits(8'h75, 0, 0, 6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_keycode", keycode, 0);
        check("midrst_ext", ext_key, 0);
        check("midrst_strobe", byte_strobe, 0);
        check("midrst_rx_byte", rx_byte, 0);
        check("midrst_err", frame_err, 0);
        m_kc = 8'h00; m_ext = 1'b0; m_pre_ext = 0; m_pre_brk = 0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h72, 0, 0);
        check_idle("after_rst", 8'h72, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- Upstream stage of the character-movement block.
- Receives raw PS/2 keyboard frames and decodes E0/F0 make/break prefixes.
- Drives a held 8-bit keycode: the code of the currently pressed key, 8'h00 when no key is held.
- Runs in the system clock domain. The PS/2 clock and data lines are treated as asynchronous inputs.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchronizer on ps2_clk and ps2_data.
- TIMEOUT_CYCLES, 50000: system-clock cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line.
- ps2_data  in  1  raw PS/2 data line.
- keycode  out  8  held keycode of the pressed key; 8'h00 when released.
- ext_key  out  1  the held keycode was E0-prefixed.
- byte_strobe  out  1  one-cycle pulse when a valid byte is received.
- rx_byte  out  8  last valid byte received; qualified by byte_strobe.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset values: all outputs 0, both state machines idle, timeout counter 0.
- Synchronizer: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is detected as previous synced = 1 and current synced = 0.

Bit level (frame state machine), 11-bit frame: start(0), D0..D7 LSB first, odd parity, stop(1). Bits are sampled on the falling-edge detect cycle.
- IDLE: on an edge with data = 0, go to DATA and set bit count to 0. On an edge with data = 1, stay in IDLE (no error).
- DATA: shift in 8 bits, then go to PARITY.
- PARITY: capture the parity bit, then go to STOP.
- STOP: if stop = 1 and parity is acceptable (see Optional Feature), pulse byte_strobe and load rx_byte one cycle after the stop edge. Otherwise pulse frame_err. Either way, return to IDLE.
- Timeout: the counter clears on every edge and whenever the frame state machine is in IDLE. If it reaches TIMEOUT_CYCLES, return to IDLE, pulse frame_err, and clear the counter.
- An edge and the timeout in the same cycle: the edge wins and the counter clears.

Byte level (prefix state machine), advances only on byte_strobe:
- NORM: E0 goes to EXT; F0 goes to BRK; any other byte is a make.
- EXT: F0 goes to EXT_BRK; any other byte is an extended make, then return to NORM.
- BRK: the byte is a break, then return to NORM.
- EXT_BRK: the byte is an extended break, then return to NORM.
- Make: on the cycle after byte_strobe, set keycode to the byte and ext_key to the extended flag. Typematic repeats of the same make leave the outputs unchanged.
- Break: only if the byte equals keycode and the extended flag matches ext_key, clear keycode and ext_key to 0 on the cycle after byte_strobe. A break for any other key is ignored (last-pressed key wins).
- frame_err returns the prefix state machine to NORM; keycode is not changed.

Latency:
- Stop-bit edge detect to byte_strobe: 1 cycle.
- byte_strobe to keycode update: 1 cycle.
- Reset asserted mid-frame: everything clears immediately. After reset release, the next frame starts clean.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the 8 data bits plus the parity bit must have an odd number of ones. Otherwise the byte is dropped, no byte_strobe is issued, and frame_err pulses.
- Undefined: the parity bit is sampled and ignored. Only the stop bit and the timeout can raise frame_err.

Decomposition:
- Package ps2_pkg holds:
  - KEY_UP 8'h75, KEY_DOWN 8'h72, KEY_LEFT 8'h6B, KEY_RIGHT 8'h74;
  - PREFIX_EXT 8'hE0, PREFIX_BRK 8'hF0;
  - the enums for the frame and prefix state machines.
- The character-movement block imports the same key constants from ps2_pkg.
- One sub-module, ps2_frame_rx, holds the synchronizer, edge detect, bit shifting, parity/stop checks and timeout. It outputs byte_strobe, rx_byte and frame_err. The top level holds the prefix state machine and the keycode register.

Test Plan:
- Extended make: frames E0, 75 → keycode = 8'h75 and ext_key = 1 two cycles after the last stop edge. byte_strobe pulses twice.
- Extended break: after the previous step, frames E0, F0, 75 → keycode = 8'h00 and ext_key = 0.
- Overlapping keys: E0 6B, then E0 74, then E0 F0 6B → keycode stays 8'h74 after the break. Then E0 F0 74 → 8'h00.
- Bad frames:
  - Frame 75 with stop bit 0 → frame_err pulse, no byte_strobe, keycode unchanged.
  - With PS2_PARITY_CHECK_EN, frame 75 with even parity → frame_err pulse. Without it → byte accepted.
- Timeout: send start plus 4 data bits, idle for 50000 cycles → frame_err at the timeout cycle. A following complete frame 72 is received correctly.
- Reset mid-frame: pull rst_n low after 6 bits → all outputs 0 immediately. After release, frames E0 72 → keycode = 8'h72.
